// File: rtl/rob_dispatch_rename.sv
// Dispatch/rename stage: takes one decoded instruction per cycle, allocates the
// ROB tail entry, renames both sources through the register alias table (RAT)
// and presents the result to issue through a registered valid/ready slot.
module rob_dispatch_rename #(
    parameter int entry_num = 21,
    parameter int tag_w     = $clog2(entry_num),
    parameter int areg_num  = 32,
    parameter int areg_w    = 5,
    parameter int op_w      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid_i,
    output logic              dec_ready_o,
    input  logic [op_w-1:0]   dec_op_i,
    input  logic [areg_w-1:0] dec_rs1_i,
    input  logic [areg_w-1:0] dec_rs2_i,
    input  logic [areg_w-1:0] dec_rd_i,
    input  logic              dec_rd_we_i,
    input  logic              rob_full_i,
    input  logic [tag_w-1:0]  rob_tag_i,
    output logic              rob_alloc_o,
    output logic              iss_valid_o,
    input  logic              iss_ready_i,
    output logic [op_w-1:0]   iss_op_o,
    output logic [tag_w-1:0]  iss_tag_o,
    output logic [areg_w-1:0] iss_rd_o,
    output logic              iss_rd_we_o,
    output logic              iss_rs1_pend_o,
    output logic [tag_w-1:0]  iss_rs1_tag_o,
    output logic              iss_rs2_pend_o,
    output logic [tag_w-1:0]  iss_rs2_tag_o,
    input  logic              cmt_valid_i,
    input  logic [tag_w-1:0]  cmt_tag_i,
    input  logic [areg_w-1:0] cmt_rd_i,
    input  logic              cmt_rd_we_i,
    input  logic              flush_i
);

    // RAT state: one pending bit and one producer tag per architectural register
    logic [areg_num-1:0] rat_pend_reg;
    logic [tag_w-1:0]    rat_tag_reg [areg_num];

    // Issue slot registers
    logic              valid_reg;
    logic [op_w-1:0]   op_reg;
    logic [tag_w-1:0]  tag_reg;
    logic [areg_w-1:0] rd_reg;
    logic              rd_we_reg;
    logic              rs1_pend_reg;
    logic [tag_w-1:0]  rs1_tag_reg;
    logic              rs2_pend_reg;
    logic [tag_w-1:0]  rs2_tag_reg;

    logic accept;
    logic alloc_we;
    logic cmt_we;
    logic rd_nonzero;
    logic rs1_pend_next;
    logic [tag_w-1:0] rs1_tag_next;
    logic rs2_pend_next;
    logic [tag_w-1:0] rs2_tag_next;
    logic [areg_num-1:0] alloc_hit;
    logic [areg_num-1:0] cmt_hit;

    assign dec_ready_o = !rst && !flush_i && !rob_full_i && (!valid_reg || iss_ready_i);
    assign accept      = dec_valid_i && dec_ready_o;
    assign rob_alloc_o = accept;
    assign rd_nonzero  = (dec_rd_i != '0);
    assign alloc_we    = accept && dec_rd_we_i && rd_nonzero;
    assign cmt_we      = cmt_valid_i && cmt_rd_we_i;

    // Source lookup; a producer retiring this very cycle is no longer pending.
    // The instruction being accepted never bypasses to itself.
    always_comb begin
        rs1_tag_next  = rat_tag_reg[dec_rs1_i];
        rs2_tag_next  = rat_tag_reg[dec_rs2_i];
        rs1_pend_next = rat_pend_reg[dec_rs1_i] && (dec_rs1_i != '0)
                        && !(cmt_we && (cmt_tag_i == rs1_tag_next));
        rs2_pend_next = rat_pend_reg[dec_rs2_i] && (dec_rs2_i != '0)
                        && !(cmt_we && (cmt_tag_i == rs2_tag_next));
    end

    // Per-register allocate / retire decode; x0 can never be allocated
    genvar gi;
    generate
        for (gi = 0; gi < areg_num; gi++) begin : g_rat_dec
            assign alloc_hit[gi] = alloc_we && (dec_rd_i == areg_w'(gi));
            assign cmt_hit[gi]   = cmt_we && (cmt_rd_i == areg_w'(gi))
                                   && (rat_tag_reg[gi] == cmt_tag_i);
        end
    endgenerate

    // RAT update: flush clears everything, a new writer beats a same-cycle retire,
    // and a retire only clears when its tag is still the newest writer
    always_ff @(posedge clk) begin
        for (int i = 0; i < areg_num; i++) begin
            if (rst) begin
                rat_pend_reg[i] <= 1'b0;
                rat_tag_reg[i]  <= '0;
            end else if (flush_i) begin
                rat_pend_reg[i] <= 1'b0;
            end else if (alloc_hit[i]) begin
                rat_pend_reg[i] <= 1'b1;
                rat_tag_reg[i]  <= rob_tag_i;
            end else if (cmt_hit[i]) begin
                rat_pend_reg[i] <= 1'b0;
            end
        end
    end

    // Issue slot: load on accept, drain on consume, keep waking held sources
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg    <= 1'b0;
            op_reg       <= '0;
            tag_reg      <= '0;
            rd_reg       <= '0;
            rd_we_reg    <= 1'b0;
            rs1_pend_reg <= 1'b0;
            rs1_tag_reg  <= '0;
            rs2_pend_reg <= 1'b0;
            rs2_tag_reg  <= '0;
        end else if (flush_i) begin
            valid_reg    <= 1'b0;
            rs1_pend_reg <= 1'b0;
            rs2_pend_reg <= 1'b0;
        end else if (accept) begin
            valid_reg    <= 1'b1;
            op_reg       <= dec_op_i;
            tag_reg      <= rob_tag_i;
            rd_reg       <= dec_rd_i;
            rd_we_reg    <= dec_rd_we_i && rd_nonzero;
            rs1_pend_reg <= rs1_pend_next;
            rs1_tag_reg  <= rs1_tag_next;
            rs2_pend_reg <= rs2_pend_next;
            rs2_tag_reg  <= rs2_tag_next;
        end else begin
            if (iss_ready_i) begin
                valid_reg <= 1'b0;
            end
            if (cmt_we && (cmt_tag_i == rs1_tag_reg)) begin
                rs1_pend_reg <= 1'b0;
            end
            if (cmt_we && (cmt_tag_i == rs2_tag_reg)) begin
                rs2_pend_reg <= 1'b0;
            end
        end
    end

    assign iss_valid_o    = valid_reg;
    assign iss_op_o       = op_reg;
    assign iss_tag_o      = tag_reg;
    assign iss_rd_o       = rd_reg;
    assign iss_rd_we_o    = rd_we_reg;
    assign iss_rs1_pend_o = rs1_pend_reg;
    assign iss_rs1_tag_o  = rs1_tag_reg;
    assign iss_rs2_pend_o = rs2_pend_reg;
    assign iss_rs2_tag_o  = rs2_tag_reg;

endmodule

// File: tb/tb_rob_dispatch_rename.sv
// Bench for rob_dispatch_rename: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_rob_dispatch_rename;

    logic       clk = 1'b0;
    logic       rst;
    logic       dec_valid;
    logic       dec_ready;
    logic [7:0] dec_op;
    logic [4:0] dec_rs1, dec_rs2, dec_rd;
    logic       dec_rd_we;
    logic       rob_full;
    logic [4:0] rob_tag;
    logic       rob_alloc;
    logic       iss_valid, iss_ready;
    logic [7:0] iss_op;
    logic [4:0] iss_tag, iss_rd;
    logic       iss_rd_we;
    logic       iss_rs1_pend, iss_rs2_pend;
    logic [4:0] iss_rs1_tag, iss_rs2_tag;
    logic       cmt_valid;
    logic [4:0] cmt_tag, cmt_rd;
    logic       cmt_rd_we;
    logic       flush;

    rob_dispatch_rename dut (
        .clk(clk), .rst(rst),
        .dec_valid_i(dec_valid), .dec_ready_o(dec_ready), .dec_op_i(dec_op),
        .dec_rs1_i(dec_rs1), .dec_rs2_i(dec_rs2), .dec_rd_i(dec_rd), .dec_rd_we_i(dec_rd_we),
        .rob_full_i(rob_full), .rob_tag_i(rob_tag), .rob_alloc_o(rob_alloc),
        .iss_valid_o(iss_valid), .iss_ready_i(iss_ready), .iss_op_o(iss_op),
        .iss_tag_o(iss_tag), .iss_rd_o(iss_rd), .iss_rd_we_o(iss_rd_we),
        .iss_rs1_pend_o(iss_rs1_pend), .iss_rs1_tag_o(iss_rs1_tag),
        .iss_rs2_pend_o(iss_rs2_pend), .iss_rs2_tag_o(iss_rs2_tag),
        .cmt_valid_i(cmt_valid), .cmt_tag_i(cmt_tag), .cmt_rd_i(cmt_rd),
        .cmt_rd_we_i(cmt_rd_we), .flush_i(flush)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    // Behavioural model: issue slot contents and a simple pending/tag table
    bit m_valid = 0;
    int m_op = 0, m_tag = 0, m_rd = 0;
    bit m_rd_we = 0, m_p1 = 0, m_p2 = 0;
    int m_t1 = 0, m_t2 = 0;
    bit rat_p [32];
    int rat_t [32];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_ready();
        return !rst && !flush && !rob_full && (!m_valid || iss_ready);
    endfunction

    // Model step at each clock edge, using the inputs the DUT samples
    always @(posedge clk) begin
        bit acc;
        bit cw;
        acc = dec_valid && exp_ready();
        cw  = cmt_valid && cmt_rd_we;
        if (rst) begin
            m_valid = 0; m_op = 0; m_tag = 0; m_rd = 0; m_rd_we = 0;
            m_p1 = 0; m_t1 = 0; m_p2 = 0; m_t2 = 0;
            for (int i = 0; i < 32; i++) begin rat_p[i] = 0; rat_t[i] = 0; end
        end else if (flush) begin
            m_valid = 0; m_p1 = 0; m_p2 = 0;
            for (int i = 0; i < 32; i++) rat_p[i] = 0;
        end else begin
            if (acc) begin
                m_valid = 1; m_op = dec_op; m_tag = rob_tag; m_rd = dec_rd;
                m_rd_we = dec_rd_we && dec_rd != 0;
                m_t1 = rat_t[dec_rs1];
                m_p1 = rat_p[dec_rs1] && !(cw && cmt_tag == m_t1);
                m_t2 = rat_t[dec_rs2];
                m_p2 = rat_p[dec_rs2] && !(cw && cmt_tag == m_t2);
            end else begin
                if (m_valid && iss_ready) m_valid = 0;
                if (cw && m_p1 && cmt_tag == m_t1) m_p1 = 0;
                if (cw && m_p2 && cmt_tag == m_t2) m_p2 = 0;
            end
            if (cw && rat_p[cmt_rd] && rat_t[cmt_rd] == cmt_tag) rat_p[cmt_rd] = 0;
            if (acc && dec_rd_we && dec_rd != 0) begin
                rat_p[dec_rd] = 1;
                rat_t[dec_rd] = rob_tag;
            end
        end
    end

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_on) begin
            chk("dec_ready", dec_ready, exp_ready());
            chk("rob_alloc", rob_alloc, dec_valid && exp_ready());
            chk("iss_valid", iss_valid, m_valid);
            if (m_valid) begin
                chk("iss_op", iss_op, m_op);
                chk("iss_tag", iss_tag, m_tag);
                chk("iss_rd", iss_rd, m_rd);
                chk("iss_rd_we", iss_rd_we, m_rd_we);
                chk("iss_rs1_pend", iss_rs1_pend, m_p1);
                chk("iss_rs2_pend", iss_rs2_pend, m_p2);
                if (m_p1) chk("iss_rs1_tag", iss_rs1_tag, m_t1);
                if (m_p2) chk("iss_rs2_tag", iss_rs2_tag, m_t2);
            end
        end
    end

    task automatic idle();
        rst = 0; dec_valid = 0; dec_op = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
        dec_rd_we = 0; rob_full = 0; rob_tag = 0; iss_ready = 1;
        cmt_valid = 0; cmt_tag = 0; cmt_rd = 0; cmt_rd_we = 0; flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic alloc(input int rd, input int tag);
        dec_valid = 1; dec_rd = 5'(rd); dec_rd_we = 1; rob_tag = 5'(tag);
    endtask

    initial begin
        idle();
        rst = 1; dec_valid = 1;
        #1;
        chk("t1_alloc_in_rst", rob_alloc, 0);
        chk("t1_ready_in_rst", dec_ready, 0);
        tick(); idle(); chk_on = 1; #1;
        chk("t1_ready", dec_ready, 1);
        chk("t1_valid", iss_valid, 0);
        chk("t1_tag", iss_tag, 0);
        chk("t1_rs1_pend", iss_rs1_pend, 0);

        // producer x3 with tag 7, then a consumer of x3
        tick(); idle(); alloc(3, 7); dec_op = 8'h11; #1;
        chk("t2_alloc", rob_alloc, 1);
        tick(); idle(); dec_valid = 1; dec_rs1 = 3; rob_tag = 8; #1;
        chk("t2_prod_tag", iss_tag, 7);
        chk("t2_prod_op", iss_op, 8'h11);
        tick(); idle(); #1;
        chk("t2_rs1_pend", iss_rs1_pend, 1);
        chk("t2_rs1_tag", iss_rs1_tag, 7);

        // lookup of x3 while tag 7 retires
        tick(); idle(); dec_valid = 1; dec_rs1 = 3; rob_tag = 9;
        cmt_valid = 1; cmt_tag = 7; cmt_rd = 3; cmt_rd_we = 1;
        tick(); idle(); dec_valid = 1; dec_rs1 = 3; rob_tag = 10; #1;
        chk("t3_fwd_pend", iss_rs1_pend, 0);
        chk("t3_fwd_tag", iss_tag, 9);
        tick(); idle(); #1;
        chk("t3_rat_clear", iss_rs1_pend, 0);

        // WAW on x5: stale retire must not clear the newer writer
        tick(); idle(); alloc(5, 2);
        tick(); idle(); alloc(5, 3);
        tick(); idle(); cmt_valid = 1; cmt_tag = 2; cmt_rd = 5; cmt_rd_we = 1;
        tick(); idle(); dec_valid = 1; dec_rs2 = 5; rob_tag = 11;
        tick(); idle(); #1;
        chk("t4_rs2_pend", iss_rs2_pend, 1);
        chk("t4_rs2_tag", iss_rs2_tag, 3);

        // stall with held pending source, then wake it by retire
        tick(); idle(); alloc(6, 4);
        tick(); idle(); dec_valid = 1; dec_rs1 = 6; dec_op = 8'hA5; rob_tag = 12;
        tick(); idle(); iss_ready = 0; rob_full = 1; alloc(7, 13); #1;
        chk("t5_held_pend", iss_rs1_pend, 1);
        chk("t5_held_tag", iss_rs1_tag, 4);
        chk("t5_ready_full", dec_ready, 0);
        chk("t5_alloc_full", rob_alloc, 0);
        tick(); idle(); iss_ready = 0; rob_full = 1;
        cmt_valid = 1; cmt_tag = 4; cmt_rd = 6; cmt_rd_we = 1;
        // flush arrives while still stalled
        tick(); idle(); iss_ready = 0; flush = 1; alloc(7, 13); #1;
        chk("t5_pend_clr", iss_rs1_pend, 0);
        chk("t5_hold_valid", iss_valid, 1);
        chk("t5_hold_tag", iss_tag, 12);
        chk("t5_hold_op", iss_op, 8'hA5);
        chk("t5_hold_rs1_tag", iss_rs1_tag, 4);
        chk("t6_ready_flush", dec_ready, 0);
        tick(); idle(); dec_valid = 1; dec_rs1 = 5; dec_rs2 = 0; dec_rd = 0;
        dec_rd_we = 1; rob_tag = 14; #1;
        chk("t6_valid_after_flush", iss_valid, 0);
        tick(); idle(); dec_valid = 1; rob_tag = 15; #1;
        chk("t6_rs1_pend_flushed", iss_rs1_pend, 0);
        chk("t6_rd0_we", iss_rd_we, 0);
        chk("t6_valid", iss_valid, 1);
        tick(); idle(); #1;
        chk("t6_x0_rs1", iss_rs1_pend, 0);
        chk("t6_x0_rs2", iss_rs2_pend, 0);

        // randomized traffic over a small register window to create hazards
        for (int n = 0; n < 4000; n++) begin
            tick();
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 63) == 0);
            rob_full  = ($urandom_range(0, 9) == 0);
            iss_ready = ($urandom_range(0, 3) != 0);
            dec_valid = ($urandom_range(0, 3) != 0);
            dec_op    = 8'($urandom);
            dec_rs1   = 5'($urandom_range(0, 7));
            dec_rs2   = 5'($urandom_range(0, 7));
            dec_rd    = 5'($urandom_range(0, 7));
            dec_rd_we = ($urandom_range(0, 3) != 0);
            rob_tag   = 5'($urandom_range(0, 20));
            cmt_valid = ($urandom_range(0, 1) != 0);
            cmt_rd    = 5'($urandom_range(0, 7));
            cmt_rd_we = ($urandom_range(0, 4) != 0);
            cmt_tag   = ($urandom_range(0, 2) != 0) ? 5'(rat_t[cmt_rd])
                                                    : 5'($urandom_range(0, 20));
        end
        tick(); idle();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
